// File: rtl/maxpool_ctrl_pkg.sv
// Shared definitions for the 2x2 max-pool controller: data width, float field
// positions used by the compare, and the two-state FSM encoding.
package maxpool_ctrl_pkg;

  localparam int DATA_W   = 32;
  localparam int SIGN_BIT = 31;
  localparam int MAG_MSB  = 30;
  localparam int MAG_W    = MAG_MSB + 1;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

endpackage

// File: rtl/maxpool_ctrl_fp_max2.sv
// Combinational IEEE-754 single max: sign first, then magnitude; +0 beats -0,
// ties return a, NaNs ordered purely by their raw magnitude bits.
module fp_max2
  import maxpool_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  logic             w_sa;
  logic             w_sb;
  logic [MAG_W-1:0] w_ma;
  logic [MAG_W-1:0] w_mb;

  assign w_sa = a[SIGN_BIT];
  assign w_sb = b[SIGN_BIT];
  assign w_ma = a[MAG_MSB:0];
  assign w_mb = b[MAG_MSB:0];

  always_comb begin
    // NOTE: y gets a default before any branch, so no path can infer a latch.
    y = a;
    if (w_sa != w_sb) begin
      y = w_sa ? b : a;
    end else if (!w_sa) begin
      y = (w_mb > w_ma) ? b : a;
    end else begin
      y = (w_mb < w_ma) ? b : a;
    end
  end

endmodule

// File: rtl/maxpool_ctrl.sv
// Streaming 2x2 stride-2 max pooling over a row-major float frame, with a
// half-row line buffer and a single output register under valid/ready flow.
module maxpool_ctrl
  import maxpool_ctrl_pkg::*;
#(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              frame_done
);

  // Column counter is at least 2 bits so the line-buffer index is never empty.
  localparam int CW     = (IMG_W > 2) ? $clog2(IMG_W) : 2;
  localparam int RW     = $clog2(IMG_H);
  localparam int LW     = CW - 1;
  localparam int LBUF_D = 2 ** LW;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  state_t            r_state;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [DATA_W-1:0] r_hold;
  logic              r_in_done;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_frame_done;
  logic [DATA_W-1:0] r_lbuf [LBUF_D];

  logic              w_run;
  logic              w_in_hs;
  logic              w_out_hs;
  logic              w_col_odd;
  logic              w_row_odd;
  logic              w_col_last;
  logic              w_row_last;
  logic              w_final;
  logic [LW-1:0]     w_lidx;
  logic [DATA_W-1:0] w_lbuf_rd;
  logic [DATA_W-1:0] w_h;
  logic [DATA_W-1:0] w_v;

  assign w_run      = (r_state == ST_RUN);
  assign w_col_odd  = r_col[0];
  assign w_row_odd  = r_row[0];
  assign w_col_last = (r_col == COL_LAST);
  assign w_row_last = (r_row == ROW_LAST);
  assign w_lidx     = r_col[CW-1:1];
  assign w_lbuf_rd  = r_lbuf[w_lidx];

  // Once the last pixel is in, input stays closed until the frame drains.
  assign in_ready   = w_run && !r_in_done && (!r_out_valid || out_ready);
  assign w_in_hs    = in_valid && in_ready;
  assign w_out_hs   = r_out_valid && out_ready;
  assign w_final    = w_run && r_in_done && w_out_hs;

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign busy       = w_run;
  assign frame_done = r_frame_done;

  fp_max2 u_hmax (
    .a (r_hold),
    .b (in_data),
    .y (w_h)
  );

  fp_max2 u_vmax (
    .a (w_h),
    .b (w_lbuf_rd),
    .y (w_v)
  );

  // NOTE: state uses <= so every register samples pre-edge values together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_hold       <= '0;
      r_in_done    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_frame_done <= 1'b0;
    end else if (!enable) begin
      r_state      <= ST_IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_hold       <= '0;
      r_in_done    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_RUN;
            r_col     <= '0;
            r_row     <= '0;
            r_in_done <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_in_hs) begin
            if (!w_col_odd) begin
              r_hold <= in_data;
            end
            if (w_col_last) begin
              r_col <= '0;
              r_row <= w_row_last ? '0 : r_row + 1'b1;
              if (w_row_last) begin
                r_in_done <= 1'b1;
              end
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
          if (w_final) begin
            r_state      <= ST_IDLE;
            r_in_done    <= 1'b0;
            r_frame_done <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // A load in the same cycle as a handshake keeps valid high with new data.
      if (w_in_hs && w_col_odd && w_row_odd) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_v;
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // NOTE: no reset on the line buffer; each entry is written on an even row
  // before the odd row reads it, so its power-up contents never matter.
  always_ff @(posedge clk) begin
    if (enable && w_in_hs && w_col_odd && !w_row_odd) begin
      r_lbuf[w_lidx] <= w_h;
    end
  end

endmodule

// File: tb/tb_maxpool_ctrl.sv
// Self-checking bench for maxpool_ctrl: directed frames, backpressure, abort,
// async reset, and a randomized 28x28 frame against an ordering-key model.
module tb_maxpool_ctrl;

  localparam int ND = 3;

  logic        clk;
  logic        rst_n;
  logic        enable     [ND];
  logic        start      [ND];
  logic        in_valid   [ND];
  logic        in_ready   [ND];
  logic [31:0] in_data    [ND];
  logic        out_valid  [ND];
  logic        out_ready  [ND];
  logic [31:0] out_data   [ND];
  logic        busy       [ND];
  logic        frame_done [ND];

  int checks;
  int errors;

  logic [31:0] px_q  [$];
  logic [31:0] exp_q [$];

  maxpool_ctrl #(.IMG_W(4), .IMG_H(4)) u_dut44 (
    .clk(clk), .rst_n(rst_n), .enable(enable[0]), .start(start[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .busy(busy[0]), .frame_done(frame_done[0])
  );

  maxpool_ctrl #(.IMG_W(4), .IMG_H(2)) u_dut42 (
    .clk(clk), .rst_n(rst_n), .enable(enable[1]), .start(start[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .busy(busy[1]), .frame_done(frame_done[1])
  );

  maxpool_ctrl #(.IMG_W(28), .IMG_H(28)) u_dut28 (
    .clk(clk), .rst_n(rst_n), .enable(enable[2]), .start(start[2]),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
    .busy(busy[2]), .frame_done(frame_done[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Total order on float bit patterns: larger key means the fmax winner.
  function automatic longint order_key(input logic [31:0] v);
    longint mag;
    mag = longint'({33'd0, v[30:0]});
    return v[31] ? (-mag - 64'sd1) : mag;
  endfunction

  function automatic void build_expected(input int w, input int h);
    logic [31:0] best;
    logic [31:0] cand;
    exp_q.delete();
    for (int oy = 0; oy < h / 2; oy++) begin
      for (int ox = 0; ox < w / 2; ox++) begin
        best = px_q[(2 * oy) * w + 2 * ox];
        for (int dy = 0; dy < 2; dy++) begin
          for (int dx = 0; dx < 2; dx++) begin
            cand = px_q[(2 * oy + dy) * w + 2 * ox + dx];
            if (order_key(cand) > order_key(best)) best = cand;
          end
        end
        exp_q.push_back(best);
      end
    end
  endfunction

  function automatic void fill_4x4();
    logic [31:0] f [16];
    f = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
          32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
          32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
          32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
    px_q.delete();
    for (int i = 0; i < 16; i++) px_q.push_back(f[i]);
    exp_q.delete();
    exp_q.push_back(32'h40C00000);
    exp_q.push_back(32'h41000000);
    exp_q.push_back(32'h41600000);
    exp_q.push_back(32'h41800000);
  endfunction

  // Drives one frame on DUT d from px_q and scores handshaken outputs against exp_q.
  task automatic run_frame(input int d, input int w, input int h, input bit rnd,
                           input bit stall, input string tag);
    int  n;
    int  nout;
    int  pi;
    int  oi;
    int  stall_left;
    bit  stall_done;
    bit  in_hs;
    bit  out_hs;
    bit  done;
    n = w * h;
    nout = n / 4;
    pi = 0;
    oi = 0;
    stall_left = 0;
    stall_done = 1'b0;
    done = 1'b0;
    @(posedge clk); #1;
    start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
    checks++;
    if (busy[d] !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_start got %b want 1", tag, busy[d]);
    end
    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      in_valid[d] = (pi < n) && (!rnd || $urandom_range(3) != 0);
      in_data[d]  = (pi < n) ? px_q[pi] : $urandom;
      if (stall && !stall_done && out_valid[d] === 1'b1) begin
        stall_done = 1'b1;
        stall_left = 5;
      end
      out_ready[d] = (stall_left == 0) && (!rnd || $urandom_range(3) != 0);
      if (rnd) start[d] = ($urandom_range(7) == 0);
      @(negedge clk);
      checks++;
      if (frame_done[d] !== 1'b0) begin
        errors++;
        $display("FAIL %s early_frame_done got %b want 0 (outputs %0d)", tag, frame_done[d], oi);
      end
      if (pi == n) begin
        checks++;
        if (in_ready[d] !== 1'b0) begin
          errors++;
          $display("FAIL %s in_ready_after_last got %b want 0", tag, in_ready[d]);
        end
      end
      if (stall_left > 0) begin
        checks++;
        if (in_ready[d] !== 1'b0 || out_valid[d] !== 1'b1 || out_data[d] !== exp_q[0]) begin
          errors++;
          $display("FAIL %s stall got in_ready=%b out_valid=%b data=%h want 0 1 %h",
                   tag, in_ready[d], out_valid[d], out_data[d], exp_q[0]);
        end
        stall_left--;
      end
      in_hs  = (in_valid[d] === 1'b1) && (in_ready[d] === 1'b1);
      out_hs = (out_valid[d] === 1'b1) && (out_ready[d] === 1'b1);
      if (out_hs) begin
        checks++;
        if (out_data[d] !== exp_q[oi]) begin
          errors++;
          $display("FAIL %s out[%0d] got %h want %h", tag, oi, out_data[d], exp_q[oi]);
        end
        oi++;
        if (oi >= nout) done = 1'b1;
      end
      if (in_hs) pi++;
      if (!done) begin
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s timeout got %0d outputs want %0d", tag, oi, nout);
    end
    @(posedge clk); #1;
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b0;
    start[d]     = 1'b0;
    @(negedge clk);
    checks++;
    if (frame_done[d] !== 1'b1 || busy[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s frame_done_pulse got fd=%b busy=%b want 1 0", tag, frame_done[d], busy[d]);
    end
    @(negedge clk);
    checks++;
    if (frame_done[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s frame_done_width got %b want 0", tag, frame_done[d]);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (out_valid[d] !== 1'b0 || busy[d] !== 1'b0 || frame_done[d] !== 1'b0 ||
          out_data[d] !== 32'h0 || in_ready[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state dut%0d got ov=%b busy=%b fd=%b data=%h ir=%b want all 0",
                 d, out_valid[d], busy[d], frame_done[d], out_data[d], in_ready[d]);
      end
    end
    rst_n = 1'b1;
    in_valid[0] = 1'b1;
    in_data[0]  = 32'h3F800000;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (in_ready[0] !== 1'b0 || busy[0] !== 1'b0) begin
        errors++;
        $display("FAIL idle_accept got in_ready=%b busy=%b want 0 0", in_ready[0], busy[0]);
      end
    end
    in_valid[0] = 1'b0;
  endtask

  task automatic test_basic();
    fill_4x4();
    run_frame(0, 4, 4, 1'b0, 1'b0, "basic4x4");
  endtask

  task automatic test_neg_zero();
    px_q = '{32'hC0400000, 32'hBF800000, 32'hC0000000, 32'hC0A00000,
             32'hC0800000, 32'h80000000, 32'h00000000, 32'hC0E00000};
    exp_q = '{32'h80000000, 32'h00000000};
    run_frame(1, 4, 2, 1'b0, 1'b0, "neg_zero4x2");
  endtask

  task automatic test_stall();
    fill_4x4();
    run_frame(0, 4, 4, 1'b0, 1'b1, "stall4x4");
  endtask

  task automatic test_enable_abort();
    int acc;
    fill_4x4();
    @(posedge clk); #1;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    out_ready[0] = 1'b1;
    acc = 0;
    for (int cyc = 0; cyc < 100 && acc < 7; cyc++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = px_q[acc];
      @(negedge clk);
      if (in_ready[0] === 1'b1) acc++;
      @(posedge clk); #1;
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    enable[0]    = 1'b0;
    checks++;
    if (acc != 7) begin
      errors++;
      $display("FAIL abort_accept got %0d pixels want 7", acc);
    end
    @(posedge clk); #1;
    checks++;
    if (busy[0] !== 1'b0 || out_valid[0] !== 1'b0 || out_data[0] !== 32'h0 || in_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_clear got busy=%b ov=%b data=%h ir=%b want 0 0 0 0",
               busy[0], out_valid[0], out_data[0], in_ready[0]);
    end
    enable[0] = 1'b1;
    run_frame(0, 4, 4, 1'b0, 1'b0, "abort_restart");
  endtask

  task automatic test_async_reset();
    int acc;
    fill_4x4();
    @(posedge clk); #1;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    out_ready[0] = 1'b0;
    acc = 0;
    for (int cyc = 0; cyc < 100 && out_valid[0] !== 1'b1; cyc++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = px_q[acc];
      @(negedge clk);
      if (in_ready[0] === 1'b1) acc++;
      @(posedge clk); #1;
    end
    in_data[0] = px_q[acc];
    checks++;
    if (out_valid[0] !== 1'b1 || out_data[0] !== 32'h40C00000) begin
      errors++;
      $display("FAIL rst_prestall got ov=%b data=%h want 1 40c00000", out_valid[0], out_data[0]);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || in_ready[0] !== 1'b0 || out_data[0] !== 32'h0) begin
      errors++;
      $display("FAIL async_reset got ov=%b busy=%b ir=%b data=%h want 0 0 0 0",
               out_valid[0], busy[0], in_ready[0], out_data[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (in_ready[0] !== 1'b0 || busy[0] !== 1'b0 || out_valid[0] !== 1'b0) begin
        errors++;
        $display("FAIL resume_needs_start got ir=%b busy=%b ov=%b want 0 0 0",
                 in_ready[0], busy[0], out_valid[0]);
      end
    end
    in_valid[0] = 1'b0;
    run_frame(0, 4, 4, 1'b0, 1'b0, "post_reset");
  endtask

  task automatic test_start_ignored();
    fill_4x4();
    run_frame(0, 4, 4, 1'b1, 1'b0, "start_in_run");
  endtask

  task automatic test_random_frame();
    logic [31:0] pool [4];
    pool = '{32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000};
    px_q.delete();
    for (int i = 0; i < 28 * 28; i++) begin
      if ($urandom_range(3) == 0) px_q.push_back(pool[$urandom_range(3)]);
      else px_q.push_back($urandom);
    end
    build_expected(28, 28);
    run_frame(2, 28, 28, 1'b1, 1'b0, "random28x28");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    for (int i = 0; i < ND; i++) begin
      enable[i]    = 1'b1;
      start[i]     = 1'b0;
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
      in_data[i]   = 32'h0;
    end
    test_reset();
    test_basic();
    test_neg_zero();
    test_stall();
    test_enable_abort();
    test_async_reset();
    test_start_ignored();
    test_random_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/maxpool_ctrl.md
MAXPOOL_CTRL -- requirements
Module: maxpool_ctrl

Interface
REQ-001 The block SHALL have parameter IMG_W, default 28, meaning input row width in pixels (even, at least 2).
REQ-002 The block SHALL have parameter IMG_H, default 28, meaning input row count (even, at least 2).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising-edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port enable, input, 1 bit: synchronous clear/abort when low.
REQ-006 The block SHALL have port start, input, 1 bit: begin one frame, sampled in IDLE only.
REQ-007 The block SHALL have port in_valid, input, 1 bit: in_data valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: pixel accepted when in_valid && in_ready.
REQ-009 The block SHALL have port in_data, input, 32 bits: IEEE-754 single pixel, row-major order.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_data valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: consumer accepts when out_valid && out_ready.
REQ-012 The block SHALL have port out_data, output, 32 bits: 2x2 pooled maximum.
REQ-013 The block SHALL have port busy, output, 1 bit: high in RUN.
REQ-014 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse when the last pooled output is accepted.

Function
REQ-015 The block SHALL compute 2x2, stride-2 max pooling: (IMG_W/2)*(IMG_H/2) outputs per frame, row-major.
REQ-016 The FSM SHALL have states IDLE and RUN; IDLE->RUN on start && enable; RUN->IDLE on the final output handshake or on enable low.
REQ-017 The block SHALL hold col (0..IMG_W-1) and row (0..IMG_H-1) counters, advanced only on an input handshake; col SHALL wrap to 0 and increment row at IMG_W-1.
REQ-018 On even col the accepted pixel SHALL be stored in a hold register.
REQ-019 On odd col the block SHALL form h = fmax(hold, pixel).
REQ-020 On an even row, h SHALL be written to line buffer entry lbuf[col/2]; no output is produced.
REQ-021 On an odd row, fmax(h, lbuf[col/2]) SHALL load the output register and set out_valid on the next clock edge (1-cycle latency).
REQ-022 in_ready SHALL equal (state==RUN) && (!out_valid || out_ready), giving single-entry skid-free backpressure.
REQ-023 out_valid SHALL hold and out_data SHALL remain stable until the output handshake.
REQ-024 A simultaneous output handshake and new load SHALL keep out_valid high with the new data.
REQ-025 fmax SHALL order by sign first: positive beats negative.
REQ-026 fmax SHALL pick the larger magnitude when both operands are positive and the smaller magnitude when both are negative.
REQ-027 fmax SHALL return +0 for +0 vs -0, and the first operand on bit-exact equality.
REQ-028 NaN inputs SHALL be ordered by raw magnitude bits, with no special handling.
REQ-029 start SHALL be ignored while in RUN.
REQ-030 Input beats while in IDLE SHALL NOT be accepted (in_ready=0).
REQ-031 enable low SHALL, on the next edge, force IDLE, clear the counters, and set out_valid=0, out_data=0, busy=0.
REQ-032 After the last input pixel in_ready SHALL stay 0 until the final output is accepted.

Reset
REQ-033 rst_n low SHALL immediately force IDLE and set col=0, row=0, hold=0, out_valid=0, out_data=0, busy=0, frame_done=0.
REQ-034 The line buffer SHALL NOT require reset, because it is always written on an even row before it is read.
REQ-035 Reset asserted mid-frame SHALL discard the frame; the next start SHALL begin at pixel (0,0).

Structure
REQ-036 A shared package SHALL hold the FSM state typedef, DATA_W=32, and the fmax-related field constants (sign bit 31, magnitude [30:0]).
REQ-037 One combinational sub-module, fp_max2 (inputs a, b; output y), SHALL implement fmax and be instantiated twice (horizontal and vertical compare).

Verification
REQ-038 The bench SHALL drive a 4x4 frame with pixels 1.0..16.0 row-major and out_ready=1, and SHALL check outputs 6.0, 8.0, 14.0, 16.0, then frame_done=1 for one cycle.
REQ-039 The bench SHALL drive a 4x2 frame (IMG_W=4, IMG_H=2) with pixels -3.0, -1.0, -2.0, -5.0 / -4.0, -0.0, +0.0, -7.0, and SHALL check outputs -0.0 then +0.0.
REQ-040 The bench SHALL hold out_ready=0 for 5 cycles after the first out_valid in scenario 038, and SHALL check that in_ready=0, out_data is stable at 6.0, and no data is lost.
REQ-041 The bench SHALL drop enable low after 7 accepted pixels, and SHALL check next-cycle IDLE, busy=0, out_valid=0; a restarted full frame SHALL yield correct results.
REQ-042 The bench SHALL assert rst_n low asynchronously mid-output-stall, and SHALL check that out_valid drops before the next clock edge and that start is required to resume.
REQ-043 The bench SHALL pulse start during RUN and SHALL check no effect on the counters; it SHALL randomize in_valid and out_ready over a 28x28 frame and compare against a reference model.
